// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
// Bundles every handshake and bus signal around mem_arbiter.
//   Requester side (ports 0 and 1):
//     m*_request_enable  one-cycle request pulse into the arbiter
//     m*_mode/addr/wdata/wstrb  request fields, sampled with the pulse
//     m*_response_enable one-cycle completion pulse back to the owner
//     m*_data            read data, valid with the matching response pulse
//   Memory side (single outstanding transaction):
//     mem_request_enable one-cycle downstream request pulse
//     mem_mode/addr/wdata/wstrb  downstream request fields
//     mem_response_enable downstream completion pulse
//     mem_data           downstream read data
//   Status:
//     overflow           sticky per-port dropped-request flag
// Modports: slave = the arbiter itself, master = the environment driving it.
// -----------------------------------------------------------------------------
interface mem_arbiter_if;
    logic        m0_request_enable;
    logic        m0_mode;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic [3:0]  m0_wstrb;
    logic        m0_response_enable;
    logic [31:0] m0_data;

    logic        m1_request_enable;
    logic        m1_mode;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic [3:0]  m1_wstrb;
    logic        m1_response_enable;
    logic [31:0] m1_data;

    logic        mem_request_enable;
    logic        mem_mode;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_response_enable;
    logic [31:0] mem_data;

    logic [1:0]  overflow;

    modport slave (
        input  m0_request_enable, m0_mode, m0_addr, m0_wdata, m0_wstrb,
        output m0_response_enable, m0_data,
        input  m1_request_enable, m1_mode, m1_addr, m1_wdata, m1_wstrb,
        output m1_response_enable, m1_data,
        output mem_request_enable, mem_mode, mem_addr, mem_wdata, mem_wstrb,
        input  mem_response_enable, mem_data,
        output overflow
    );

    modport master (
        output m0_request_enable, m0_mode, m0_addr, m0_wdata, m0_wstrb,
        input  m0_response_enable, m0_data,
        output m1_request_enable, m1_mode, m1_addr, m1_wdata, m1_wstrb,
        input  m1_response_enable, m1_data,
        input  mem_request_enable, mem_mode, mem_addr, mem_wdata, mem_wstrb,
        output mem_response_enable, mem_data,
        input  overflow
    );
endinterface

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares a single-outstanding, pulse-style memory bus between the core data
// port (port 0) and the virtio DMA controller (port 1). Each port owns one
// pending slot; the bus is granted round-robin, one transaction at a time, and
// every response is steered back to the port that issued the transaction.
// Ports:
//   clk   system clock, all state on the rising edge
//   rstn  asynchronous active-low reset
//   bus   mem_arbiter_if.slave (requester ports, memory bus, overflow flags)
// All outputs are registered; there is no combinational path from a request
// pulse to the memory-side outputs.
// -----------------------------------------------------------------------------
module mem_arbiter (
    input  logic           clk,
    input  logic           rstn,
    mem_arbiter_if.slave   bus
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    // Arbitration state
    state_t           r_state;
    logic             r_last_grant;
    logic             r_owner;

    // Pending slots, index = port number
    logic [1:0]       r_valid;
    logic [1:0]       r_mode;
    logic [1:0][31:0] r_addr;
    logic [1:0][31:0] r_wdata;
    logic [1:0][3:0]  r_wstrb;

    // Registered outputs
    logic             r_mem_req;
    logic             r_mem_mode;
    logic [31:0]      r_mem_addr;
    logic [31:0]      r_mem_wdata;
    logic [3:0]       r_mem_wstrb;
    logic [1:0]       r_resp;
    logic [1:0][31:0] r_data;
    logic [1:0]       r_overflow;

    // Incoming request fields, index = port number
    logic [1:0]       w_req;
    logic [1:0]       w_in_mode;
    logic [1:0][31:0] w_in_addr;
    logic [1:0][31:0] w_in_wdata;
    logic [1:0][3:0]  w_in_wstrb;

    // Arbitration decision for the current edge
    logic [1:0]       w_cand;
    logic             w_issue;
    logic             w_sel;
    logic [1:0]       w_iss_port;
    logic             w_iss_mode;
    logic [31:0]      w_iss_addr;
    logic [31:0]      w_iss_wdata;
    logic [3:0]       w_iss_wstrb;

    assign w_req      = {bus.m1_request_enable, bus.m0_request_enable};
    assign w_in_mode  = {bus.m1_mode,  bus.m0_mode};
    assign w_in_addr  = {bus.m1_addr,  bus.m0_addr};
    assign w_in_wdata = {bus.m1_wdata, bus.m0_wdata};
    assign w_in_wstrb = {bus.m1_wstrb, bus.m0_wstrb};

    // A port is a candidate if its slot is full or it is pulsing right now;
    // the live pulse lets an idle bus issue on the very edge that samples it.
    assign w_cand  = r_valid | w_req;
    assign w_issue = (r_state == ST_IDLE) && (w_cand != 2'b00);

    // Round-robin pick: a tie goes to the port that was not granted last.
    always_comb begin
        w_sel = 1'b0;
        case (w_cand)
            2'b01:   w_sel = 1'b0;
            2'b10:   w_sel = 1'b1;
            2'b11:   w_sel = ~r_last_grant;
            default: w_sel = 1'b0;
        endcase
    end

    // One-hot view of which port is issued on this edge (none when not issuing).
    always_comb begin
        w_iss_port = 2'b00;
        if (w_issue) begin
            w_iss_port = w_sel ? 2'b10 : 2'b01;
        end else begin
            w_iss_port = 2'b00;
        end
    end

    // Issued fields come from the slot if it is full, else from the live pulse.
    always_comb begin
        w_iss_mode  = 1'b0;
        w_iss_addr  = 32'h0000_0000;
        w_iss_wdata = 32'h0000_0000;
        w_iss_wstrb = 4'h0;
        if (r_valid[w_sel]) begin
            w_iss_mode  = r_mode[w_sel];
            w_iss_addr  = r_addr[w_sel];
            w_iss_wdata = r_wdata[w_sel];
            w_iss_wstrb = r_wstrb[w_sel];
        end else begin
            w_iss_mode  = w_in_mode[w_sel];
            w_iss_addr  = w_in_addr[w_sel];
            w_iss_wdata = w_in_wdata[w_sel];
            w_iss_wstrb = w_in_wstrb[w_sel];
        end
    end

    // Arbiter FSM, pending slots and all registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_valid      <= 2'b00;
            r_mode       <= 2'b00;
            r_addr       <= {2{32'h0000_0000}};
            r_wdata      <= {2{32'h0000_0000}};
            r_wstrb      <= {2{4'h0}};
            r_mem_req    <= 1'b0;
            r_mem_mode   <= 1'b0;
            r_mem_addr   <= 32'h0000_0000;
            r_mem_wdata  <= 32'h0000_0000;
            r_mem_wstrb  <= 4'h0;
            r_resp       <= 2'b00;
            r_data       <= {2{32'h0000_0000}};
            r_overflow   <= 2'b00;
        end else begin
            // Pulses default low; only the branches below raise them.
            r_mem_req <= 1'b0;
            r_resp    <= 2'b00;

            case (r_state)
                ST_IDLE: begin
                    // A response seen here is spurious or stale and is ignored.
                    if (w_issue) begin
                        r_mem_req   <= 1'b1;
                        r_mem_mode  <= w_iss_mode;
                        r_mem_addr  <= w_iss_addr;
                        r_mem_wdata <= w_iss_wdata;
                        r_mem_wstrb <= w_iss_wstrb;
                        r_owner     <= w_sel;
                        r_state     <= ST_WAIT;
                    end else begin
                        r_state     <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (bus.mem_response_enable) begin
                        r_resp[r_owner] <= 1'b1;
                        r_data[r_owner] <= bus.mem_data;
                        r_last_grant    <= r_owner;
                        r_state         <= ST_IDLE;
                    end else begin
                        r_state         <= ST_WAIT;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            for (int i = 0; i < 2; i++) begin
                if (w_req[i]) begin
                    if (r_valid[i] && !w_iss_port[i]) begin
                        // Slot still occupied: drop the new request.
                        r_overflow[i] <= 1'b1;
                    end else if (!r_valid[i] && w_iss_port[i]) begin
                        // Empty slot, pulse issued straight to the bus.
                        r_valid[i] <= 1'b0;
                    end else begin
                        // Empty slot, or old entry leaving on this edge.
                        r_valid[i] <= 1'b1;
                        r_mode[i]  <= w_in_mode[i];
                        r_addr[i]  <= w_in_addr[i];
                        r_wdata[i] <= w_in_wdata[i];
                        r_wstrb[i] <= w_in_wstrb[i];
                    end
                end else if (w_iss_port[i]) begin
                    r_valid[i] <= 1'b0;
                end else begin
                    r_valid[i] <= r_valid[i];
                end
            end
        end
    end

    assign bus.mem_request_enable = r_mem_req;
    assign bus.mem_mode           = r_mem_mode;
    assign bus.mem_addr           = r_mem_addr;
    assign bus.mem_wdata          = r_mem_wdata;
    assign bus.mem_wstrb          = r_mem_wstrb;
    assign bus.m0_response_enable = r_resp[0];
    assign bus.m1_response_enable = r_resp[1];
    assign bus.m0_data            = r_data[0];
    assign bus.m1_data            = r_data[1];
    assign bus.overflow           = r_overflow;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed bench for mem_arbiter: reset values, single read, simultaneous
// requests, round-robin alternation, overflow, spurious response and reset in
// the middle of a transaction. Inputs change 1 time unit after the rising
// edge; outputs are compared at that same point, away from the edge.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    logic clk;
    logic rstn;
    int   n_cmp;
    int   n_mis;

    mem_arbiter_if bus ();

    mem_arbiter dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.m0_request_enable   = 1'b0;
        bus.m1_request_enable   = 1'b0;
        bus.mem_response_enable = 1'b0;
    endtask

    task automatic req0(input logic mode, input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
        bus.m0_request_enable = 1'b1;
        bus.m0_mode  = mode;
        bus.m0_addr  = addr;
        bus.m0_wdata = wdata;
        bus.m0_wstrb = wstrb;
    endtask

    task automatic req1(input logic mode, input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
        bus.m1_request_enable = 1'b1;
        bus.m1_mode  = mode;
        bus.m1_addr  = addr;
        bus.m1_wdata = wdata;
        bus.m1_wstrb = wstrb;
    endtask

    task automatic respond(input logic [31:0] data);
        bus.mem_response_enable = 1'b1;
        bus.mem_data            = data;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        clear_inputs();
        step();
        step();
        rstn = 1'b1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".mem_req"},   bus.mem_request_enable, 32'h0);
        chk({tag, ".mem_addr"},  bus.mem_addr,  32'h0);
        chk({tag, ".mem_wdata"}, bus.mem_wdata, 32'h0);
        chk({tag, ".mem_wstrb"}, bus.mem_wstrb, 32'h0);
        chk({tag, ".mem_mode"},  bus.mem_mode,  32'h0);
        chk({tag, ".m0_resp"},   bus.m0_response_enable, 32'h0);
        chk({tag, ".m1_resp"},   bus.m1_response_enable, 32'h0);
        chk({tag, ".m0_data"},   bus.m0_data, 32'h0);
        chk({tag, ".m1_data"},   bus.m1_data, 32'h0);
        chk({tag, ".overflow"},  bus.overflow, 32'h0);
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        rstn  = 1'b0;
        clear_inputs();
        bus.m0_mode = 1'b0; bus.m0_addr = 32'h0; bus.m0_wdata = 32'h0; bus.m0_wstrb = 4'h0;
        bus.m1_mode = 1'b0; bus.m1_addr = 32'h0; bus.m1_wdata = 32'h0; bus.m1_wstrb = 4'h0;
        bus.mem_data = 32'h0;

        // ---- reset state
        do_reset();
        chk_reset_outputs("reset");

        // ---- single read from port 1
        req1(1'b0, 32'h8000_1002, 32'h0, 4'h0);
        step();
        clear_inputs();
        chk("t1.mem_req",  bus.mem_request_enable, 32'h1);
        chk("t1.mem_addr", bus.mem_addr, 32'h8000_1002);
        chk("t1.mem_mode", bus.mem_mode, 32'h0);
        step();
        chk("t1.mem_req_pulse", bus.mem_request_enable, 32'h0);
        step();
        respond(32'h0000_0005);
        step();
        clear_inputs();
        chk("t1.m1_resp", bus.m1_response_enable, 32'h1);
        chk("t1.m1_data", bus.m1_data, 32'h0000_0005);
        chk("t1.m0_resp", bus.m0_response_enable, 32'h0);
        step();
        chk("t1.m1_resp_pulse", bus.m1_response_enable, 32'h0);
        chk("t1.m1_data_hold",  bus.m1_data, 32'h0000_0005);

        // ---- simultaneous requests after reset: port 0 wins first tie
        do_reset();
        req0(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF);
        req1(1'b0, 32'h0000_0200, 32'h0, 4'h0);
        step();
        clear_inputs();
        chk("t2.req0",   bus.mem_request_enable, 32'h1);
        chk("t2.addr0",  bus.mem_addr,  32'h0000_0100);
        chk("t2.mode0",  bus.mem_mode,  32'h1);
        chk("t2.wdata0", bus.mem_wdata, 32'hDEAD_BEEF);
        chk("t2.wstrb0", bus.mem_wstrb, 32'hF);
        respond(32'h0000_0011);
        step();
        clear_inputs();
        chk("t2.m0_resp",  bus.m0_response_enable, 32'h1);
        chk("t2.m1_resp0", bus.m1_response_enable, 32'h0);
        chk("t2.m0_data",  bus.m0_data, 32'h0000_0011);
        chk("t2.gap",      bus.mem_request_enable, 32'h0);
        step();
        chk("t2.req1",  bus.mem_request_enable, 32'h1);
        chk("t2.addr1", bus.mem_addr, 32'h0000_0200);
        chk("t2.mode1", bus.mem_mode, 32'h0);
        respond(32'h0000_0022);
        step();
        clear_inputs();
        chk("t2.m1_resp",  bus.m1_response_enable, 32'h1);
        chk("t2.m0_resp1", bus.m0_response_enable, 32'h0);
        chk("t2.m1_data",  bus.m1_data, 32'h0000_0022);

        // ---- round-robin with both slots kept full
        do_reset();
        req0(1'b0, 32'h0000_0000, 32'h0, 4'h0);
        req1(1'b0, 32'h0000_1000, 32'h0, 4'h0);
        step();
        clear_inputs();
        for (int n = 0; n < 8; n++) begin
            logic        p;
            logic [31:0] k;
            p = n[0];
            k = n / 2;
            chk($sformatf("rr%0d.req", n),  bus.mem_request_enable, 32'h1);
            chk($sformatf("rr%0d.addr", n), bus.mem_addr, (p ? 32'h0000_1000 : 32'h0000_0000) + k);
            if (p) req1(1'b0, 32'h0000_1000 + k + 32'h1, 32'h0, 4'h0);
            else   req0(1'b0, 32'h0000_0000 + k + 32'h1, 32'h0, 4'h0);
            respond(32'h0000_0000 + n);
            step();
            clear_inputs();
            chk($sformatf("rr%0d.m0_resp", n), bus.m0_response_enable, {31'h0, ~p});
            chk($sformatf("rr%0d.m1_resp", n), bus.m1_response_enable, {31'h0, p});
            step();
        end

        // ---- overflow: three back-to-back port-0 pulses around port-1 traffic
        do_reset();
        req1(1'b0, 32'h0000_0300, 32'h0, 4'h0);
        step();
        clear_inputs();
        chk("ov.m1_issue", bus.mem_addr, 32'h0000_0300);
        step();
        req0(1'b0, 32'h0000_00A0, 32'h0, 4'h0);
        respond(32'h0000_0033);
        step();
        clear_inputs();
        chk("ov.m1_resp", bus.m1_response_enable, 32'h1);
        chk("ov.m1_data", bus.m1_data, 32'h0000_0033);
        chk("ov.flag_a",  bus.overflow, 32'h0);
        req0(1'b0, 32'h0000_00A1, 32'h0, 4'h0);
        step();
        clear_inputs();
        chk("ov.issue_a0", bus.mem_request_enable, 32'h1);
        chk("ov.addr_a0",  bus.mem_addr, 32'h0000_00A0);
        req0(1'b0, 32'h0000_00A2, 32'h0, 4'h0);
        step();
        clear_inputs();
        chk("ov.flag", bus.overflow, 32'h1);
        respond(32'h0000_0044);
        step();
        clear_inputs();
        chk("ov.m0_resp_a0", bus.m0_response_enable, 32'h1);
        chk("ov.m0_data_a0", bus.m0_data, 32'h0000_0044);
        step();
        chk("ov.issue_a1", bus.mem_request_enable, 32'h1);
        chk("ov.addr_a1",  bus.mem_addr, 32'h0000_00A1);
        respond(32'h0000_0055);
        step();
        clear_inputs();
        chk("ov.m0_resp_a1", bus.m0_response_enable, 32'h1);
        step();
        chk("ov.no_a2",     bus.mem_request_enable, 32'h0);
        chk("ov.flag_keep", bus.overflow, 32'h1);
        chk("ov.m1_quiet",  bus.m1_response_enable, 32'h0);

        // ---- spurious response in idle
        respond(32'h0000_0099);
        step();
        clear_inputs();
        chk("sp.m0_resp", bus.m0_response_enable, 32'h0);
        chk("sp.m1_resp", bus.m1_response_enable, 32'h0);
        chk("sp.m0_data", bus.m0_data, 32'h0000_0055);
        chk("sp.m1_data", bus.m1_data, 32'h0000_0033);
        chk("sp.mem_req", bus.mem_request_enable, 32'h0);

        // ---- reset while a port-1 read is outstanding; late response ignored
        req1(1'b0, 32'h0000_0400, 32'h0, 4'h0);
        step();
        clear_inputs();
        chk("rm.issue", bus.mem_addr, 32'h0000_0400);
        do_reset();
        respond(32'h0000_0077);
        step();
        clear_inputs();
        chk_reset_outputs("rm");
        step();
        chk("rm.m1_resp_late", bus.m1_response_enable, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
